// File: rtl/ternary_word_engine.sv
// ternary_word_engine
//   Trit-serial front end for the ternary gate library. The engine accepts two
//   N_TRITS-trit words and an op code, then evaluates one trit per clock, LSB
//   first. The finished word is returned on a second handshake.
//
//   Trit encoding: 2'b00 = '-', 2'b01 = '0', 2'b10 = '+', 2'b11 = invalid.
//
//   Handshake rule (both sides): a transfer happens on the rising clk edge
//   where valid and ready are both 1. Once out_valid is raised, the producer
//   holds out_word/out_err stable until that transfer.
//
// Ports
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   in_valid    operands and op presented
//   in_ready    engine idle and able to accept
//   op          00 MIN, 01 MAX, 10 CONSENSUS, 11 ANY
//   a_word      operand A, trit i = a_word[2i+1:2i]
//   b_word      operand B
//   out_valid   result available
//   out_ready   consumer takes the result
//   out_word    result word
//   out_err     at least one invalid trit was seen in this word
module ternary_word_engine #(
  parameter int N_TRITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [2*N_TRITS-1:0] a_word,
  input  logic [2*N_TRITS-1:0] b_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N_TRITS-1:0] out_word,
  output logic                 out_err
);

  localparam int W     = 2 * N_TRITS;
  localparam int CNT_W = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_TRITS - 1);
  localparam logic [W-1:0]     ZERO_WORD = {N_TRITS{2'b01}};

  localparam logic [1:0] T_ZERO = 2'b01;
  localparam logic [1:0] T_BAD  = 2'b11;

  localparam logic [1:0] OP_MIN = 2'b00;
  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_CON = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Kept as a plain named register so checkers can bind to it directly.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [1:0]       op_q;

  logic [1:0] cur_a;
  logic [1:0] cur_b;
  logic [1:0] cur_res;
  logic       cur_bad;

  // Single-trit evaluation. The valid encodings are numerically ordered
  // (- < 0 < +), so MIN/MAX reduce to an unsigned compare.
  function automatic logic [1:0] trit_op(input logic [1:0] op_sel,
                                         input logic [1:0] x,
                                         input logic [1:0] y);
    logic [1:0] r;
    r = T_ZERO;
    case (op_sel)
      OP_MIN:  r = (x < y) ? x : y;
      OP_MAX:  r = (x > y) ? x : y;
      OP_CON:  r = (x == y) ? x : T_ZERO;
      default: begin
        // ANY: agreement wins, a '0' defers to the other side, +/- cancel.
        if (x == y)           r = x;
        else if (x == T_ZERO) r = y;
        else if (y == T_ZERO) r = x;
        else                  r = T_ZERO;
      end
    endcase
    return r;
  endfunction

  always_comb begin
    cur_a   = a_q[{cnt, 1'b0} +: 2];
    cur_b   = b_q[{cnt, 1'b0} +: 2];
    cur_bad = (cur_a == T_BAD) || (cur_b == T_BAD);
    cur_res = cur_bad ? T_ZERO : trit_op(op_q, cur_a, cur_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_word  <= ZERO_WORD;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // in_ready is 1 throughout IDLE, so in_valid alone marks acceptance.
          if (in_valid) begin
            a_q      <= a_word;
            b_q      <= b_word;
            op_q     <= op;
            out_word <= ZERO_WORD;
            out_err  <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          out_word[{cnt, 1'b0} +: 2] <= cur_res;
          if (cur_bad) out_err <= 1'b1;
          if (cnt == LAST_CNT) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_word_engine.sv
// Bench for ternary_word_engine (N_TRITS = 4): directed words, output
// back-pressure, mid-run reset and randomized traffic, all scored against a
// trit-level reference model.
module tb_ternary_word_engine;

  localparam int N  = 4;
  localparam int W  = 2 * N;
  localparam int EW = W + 1;  // {err, word}

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_word;
  logic         out_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ternary_word_engine #(.N_TRITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 0;  // 0 random, 1 held low, 2 always high
  bit            seen_valid = 0;

  // ---------------- reference model ----------------
  function automatic int t2i(input logic [1:0] t);
    return int'(t) - 1;  // 00 -> -1, 01 -> 0, 10 -> +1
  endfunction

  function automatic logic [EW-1:0] ref_word(input logic [1:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] w;
    logic         err;
    logic [1:0]   ta, tb;
    int           x, y, r;
    w   = '0;
    err = 1'b0;
    for (int i = 0; i < N; i++) begin
      ta = a[2*i +: 2];
      tb = b[2*i +: 2];
      if (ta == 2'b11 || tb == 2'b11) begin
        err = 1'b1;
        r   = 0;
      end else begin
        x = t2i(ta);
        y = t2i(tb);
        case (o)
          2'd0:    r = (x < y) ? x : y;
          2'd1:    r = (x > y) ? x : y;
          2'd2:    r = (x == y) ? x : 0;
          default: r = (x + y > 0) ? 1 : ((x + y < 0) ? -1 : 0);
        endcase
      end
      w[2*i +: 2] = 2'(r + 1);
    end
    return {err, w};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < N; i++)
      w[2*i +: 2] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    return w;
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            acc;
    if (rst_n) begin
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL latency: out_valid with no accepted word at cycle %0d", cyc);
        end else if (cyc - acc_q[0] != N) begin
          errors++;
          $display("FAIL latency: got %0d edges, expected %0d", cyc - acc_q[0], N);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: word %h err %b with empty queue", out_word, out_err);
        end else begin
          e = exp_q.pop_front();
          if (acc_q.size() != 0) acc = acc_q.pop_front();
          if ({out_err, out_word} !== e) begin
            errors++;
            $display("FAIL result: got err=%b word=%h, expected err=%b word=%h",
                     out_err, out_word, e[W], e[W-1:0]);
          end
        end
        seen_valid = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    ok = 1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ok = 0;
      errors++;
      checks++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
  endtask

  task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    wait_idle(ok);
    if (ok) begin
      in_valid = 1'b1;
      op       = o;
      a_word   = a;
      b_word   = b;
      @(posedge clk);
      exp_q.push_back(ref_word(o, a, b));
      #1;
      acc_q.push_back(cyc);
      in_valid = 1'b0;
      // Scramble inputs: the latched copies must be used.
      op     = 2'($urandom_range(0, 3));
      a_word = W'($urandom);
      b_word = W'($urandom);
      @(negedge clk);
      check("in_ready_in_run", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [EW-1:0] e;
    bit            ok;
    int            n;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    check("reset_out_word", 32'(out_word), 32'h55);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed words under random back-pressure.
    send(2'b00, 8'h92, 8'h1A);
    send(2'b01, 8'h92, 8'h1A);
    send(2'b10, 8'h92, 8'h1A);
    send(2'b11, 8'h50, 8'h81);
    send(2'b00, 8'hD5, 8'h55);
    send(2'b01, 8'hAA, 8'hAA);
    send(2'b11, 8'h02, 8'h28);
    drain();

    // Back-pressure: hold result for 5 cycles while poking the inputs.
    rdy_mode = 1;
    send(2'b00, 8'h92, 8'h1A);
    e = ref_word(2'b00, 8'h92, 8'h1A);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      op       = op + 2'd1;
      a_word   = W'($urandom);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_word", 32'(out_word), 32'(e[W-1:0]));
    end
    in_valid = 1'b0;
    rdy_mode = 2;
    drain();

    // Reset at cnt == 2 while running; the word must never be delivered.
    wait_idle(ok);
    if (ok) begin
      in_valid = 1'b1;
      op       = 2'b01;
      a_word   = 8'hAA;
      b_word   = 8'h00;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_word", 32'(out_word), 32'h55);
      check("rst_out_err", 32'(out_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("rst_no_output", 32'(out_valid), 32'd0);
    end
    send(2'b10, 8'h96, 8'h9A);
    drain();

    // Randomized traffic with random back-pressure.
    rdy_mode = 0;
    for (int i = 0; i < 40; i++)
      send(2'($urandom_range(0, 3)), rand_word(), rand_word());
    drain();

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
